pt_check: RTL

Plaintext validator: reads a length-prefixed message from the plaintext memory after the ARC4 core has written it, and reports whether every message byte is printable ASCII. It is the read-side consumer of the ARC4 core's plaintext output and the per-key verdict source for the key-search (cracking) controller. It uses the same `en`/`rdy` start handshake as `arc4` and the same synchronous-read memory port style.

---
 rtl/pt_check.sv | 76 +++++++
 1 files changed

// File: rtl/pt_check.sv
// Printable-ASCII validator for a length-prefixed message in the plaintext memory.
// Each byte costs one WAIT and one SAMPLE cycle. The check stops early at the first rejected byte.
module pt_check #(
  parameter logic [7:0] LO_CHAR = 8'h20,
  parameter logic [7:0] HI_CHAR = 8'h7E
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  output logic       rdy,
  output logic [7:0] pt_addr,
  input  logic [7:0] pt_rddata,
  output logic       valid,
  output logic [7:0] bad_idx
);

  typedef enum logic [1:0] {IDLE, WAIT, SAMPLE} state_t;

  state_t     state;
  logic [7:0] len;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      rdy     <= 1'b1;
      pt_addr <= 8'd0;
      valid   <= 1'b0;
      bad_idx <= 8'd0;
      len     <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          if (en) begin
            pt_addr <= 8'd0;
            valid   <= 1'b0;
            bad_idx <= 8'd0;
            rdy     <= 1'b0;
            state   <= WAIT;
          end
        end
        // The memory registers pt_addr on this edge; its data is sampled on the next one.
        WAIT: state <= SAMPLE;
        SAMPLE: begin
          if (pt_addr == 8'd0) begin
            len <= pt_rddata;
            if (pt_rddata == 8'd0) begin
              valid   <= 1'b0;
              bad_idx <= 8'd0;
              rdy     <= 1'b1;
              state   <= IDLE;
            end else begin
              pt_addr <= 8'd1;
              state   <= WAIT;
            end
          end else if (pt_rddata < LO_CHAR || pt_rddata > HI_CHAR) begin
            valid   <= 1'b0;
            bad_idx <= pt_addr;
            rdy     <= 1'b1;
            state   <= IDLE;
          end else if (pt_addr == len) begin
            // Stopping at len keeps the 8-bit address from wrapping when len is 255.
            valid   <= 1'b1;
            bad_idx <= 8'd0;
            rdy     <= 1'b1;
            state   <= IDLE;
          end else begin
            pt_addr <= pt_addr + 8'd1;
            state   <= WAIT;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
